// File: rtl/imem_readback_tx.sv
// imem_readback_tx: reads consecutive iMem words and sends each one as a
// zero-padded {adr, data} frame, MSB byte first, over the io_b byte bus.
// A slow software-visible strobe marks each byte. The receiver samples the
// byte on the strobe's rising edge.
module imem_readback_tx #(
  parameter int ADR_W       = 10,
  parameter int DATA_W      = 40,
  parameter int HALF_PERIOD = 4
) (
  input  logic              clk_int,
  input  logic              reset,
  input  logic              start,
  input  logic [ADR_W-1:0]  start_adr,
  input  logic [ADR_W:0]    word_count,
  output logic              imem_rd_en,
  output logic [ADR_W-1:0]  imem_rd_adr,
  input  logic [DATA_W-1:0] imem_rd_data,
  output logic [7:0]        tx_byte,
  output logic              tx_strobe,
  output logic              tx_oe,
  output logic              busy,
  output logic              done
);

  localparam int BYTES   = (ADR_W + DATA_W + 7) / 8;
  localparam int FRAME_W = BYTES * 8;
  localparam int PH_W    = $clog2(HALF_PERIOD + 1);
  localparam int BC_W    = $clog2(BYTES + 1);
  localparam int CNT_W   = ADR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SETUP,
    HIGH,
    FINISH
  } state_t;

  state_t             state;
  logic [ADR_W-1:0]   adr;
  logic [CNT_W-1:0]   cnt;
  logic [PH_W-1:0]    phase;
  logic [BC_W-1:0]    byte_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_load;

  // Build the padded frame for the word arriving from iMem this cycle
  always_comb begin
    frame_load = '0;
    frame_load[ADR_W+DATA_W-1:0] = {adr, imem_rd_data};
  end

  // Transfer sequencer; every output is registered and updated with the state
  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      adr         <= '0;
      cnt         <= '0;
      phase       <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      imem_rd_en  <= 1'b0;
      imem_rd_adr <= '0;
      tx_byte     <= '0;
      tx_strobe   <= 1'b0;
      tx_oe       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              adr         <= start_adr;
              cnt         <= word_count;
              imem_rd_en  <= 1'b1;
              imem_rd_adr <= start_adr;
              busy        <= 1'b1;
              tx_oe       <= 1'b1;
              state       <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        FETCH: begin
          imem_rd_en <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          shreg    <= frame_load;
          tx_byte  <= frame_load[FRAME_W-1 -: 8];
          byte_cnt <= BC_W'(BYTES - 1);
          phase    <= '0;
          state    <= SETUP;
        end
        SETUP: begin
          if (phase == PH_W'(HALF_PERIOD - 1)) begin
            phase     <= '0;
            tx_strobe <= 1'b1;
            state     <= HIGH;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        HIGH: begin
          if (phase == PH_W'(HALF_PERIOD - 1)) begin
            phase     <= '0;
            tx_strobe <= 1'b0;
            if (byte_cnt != '0) begin
              shreg    <= shreg << 8;
              tx_byte  <= shreg[FRAME_W-9 -: 8];
              byte_cnt <= byte_cnt - BC_W'(1);
              state    <= SETUP;
            end else if (cnt > CNT_W'(1)) begin
              adr         <= adr + ADR_W'(1);
              cnt         <= cnt - CNT_W'(1);
              imem_rd_en  <= 1'b1;
              imem_rd_adr <= adr + ADR_W'(1);
              state       <= FETCH;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              tx_oe   <= 1'b0;
              tx_byte <= '0;
              state   <= FINISH;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
